// File: rtl/board_register_file_pkg.sv
// Shared types for the N-queens occupancy board: write opcodes and clear-sweep states.
package queen_pkg;

  typedef enum logic [1:0] {
    ROW_LOAD = 2'd0,
    BIT_SET  = 2'd1,
    BIT_CLR  = 2'd2,
    BIT_TOG  = 2'd3
  } wr_mode_t;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } clr_state_t;

endpackage

// File: rtl/board_register_file_if.sv
// Solver-to-board bus: write/clear commands, row read port and placement probe.
interface board_register_file_if #(parameter int N = 8);
  import queen_pkg::*;

  localparam int RW = $clog2(N);

  logic            clr_start;
  logic            busy;
  logic            wr_en;
  wr_mode_t        wr_mode;
  logic [RW-1:0]   wr_row;
  logic [RW-1:0]   wr_col;
  logic [N-1:0]    wr_data;
  logic [RW-1:0]   rd_row;
  logic [N-1:0]    rd_data;
  logic [N-1:0]    col_occ;
  logic [RW-1:0]   chk_row;
  logic [RW-1:0]   chk_col;
  logic            chk_safe;

  modport master (
    output clr_start, wr_en, wr_mode, wr_row, wr_col, wr_data, rd_row, chk_row, chk_col,
    input  busy, rd_data, col_occ, chk_safe
  );

  modport slave (
    input  clr_start, wr_en, wr_mode, wr_row, wr_col, wr_data, rd_row, chk_row, chk_col,
    output busy, rd_data, col_occ, chk_safe
  );

endinterface

// File: rtl/board_register_file_diag_checker.sv
// Combinational attack check: is (chk_row, chk_col) free of queens in any earlier row
// along its column or either diagonal. Out-of-board diagonal columns simply never match.
module diag_checker #(
  parameter int N = 8,
  localparam int RW = $clog2(N)
) (
  input  logic [N-1:0][N-1:0] board,
  input  logic [RW-1:0]       chk_row,
  input  logic [RW-1:0]       chk_col,
  output logic                safe
);

  int cr;
  int cc;

  always_comb begin
    cr   = int'(chk_row);
    cc   = int'(chk_col);
    safe = (cr < N) && (cc < N);
    for (int r = 0; r < N; r++) begin
      for (int c = 0; c < N; c++) begin
        if (board[r][c] && (r < cr)) begin
          if ((c == cc) || (c == cc - (cr - r)) || (c == cc + (cr - r))) begin
            safe = 1'b0;
          end
        end
      end
    end
  end

endmodule

// File: rtl/board_register_file.sv
// N x N queen occupancy board: per-row/per-bit writes, a sequential clear sweep,
// and registered row read, column occupancy and placement-safety outputs.
module board_register_file
  import queen_pkg::*;
#(
  parameter int N = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  board_register_file_if.slave  bus
);

  localparam int RW = $clog2(N);

  logic [N-1:0][N-1:0] rows;
  clr_state_t          state;
  clr_state_t          state_nxt;
  logic [RW-1:0]       cnt;
  logic [RW-1:0]       cnt_nxt;
  logic                busy;
  logic                safe_comb;
  logic [N-1:0]        rd_sel;
  logic [N-1:0]        occ;

  assign busy     = (state == CLEAR);
  assign bus.busy = busy;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (bus.clr_start) begin
          state_nxt = CLEAR;
          cnt_nxt   = '0;
        end
      end
      CLEAR: begin
        if (cnt == RW'(N - 1)) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Index decode by comparison so out-of-range rows/cols (non-power-of-2 N) match nothing.
  always_ff @(posedge clk) begin
    if (rst) begin
      rows <= '0;
    end else if (busy) begin
      for (int i = 0; i < N; i++) begin
        if (cnt == RW'(i)) rows[i] <= '0;
      end
    end else if (bus.wr_en) begin
      for (int i = 0; i < N; i++) begin
        if (bus.wr_row == RW'(i)) begin
          if (bus.wr_mode == ROW_LOAD) begin
            rows[i] <= bus.wr_data;
          end else begin
            for (int j = 0; j < N; j++) begin
              if (bus.wr_col == RW'(j)) begin
                case (bus.wr_mode)
                  BIT_SET: rows[i][j] <= 1'b1;
                  BIT_CLR: rows[i][j] <= 1'b0;
                  BIT_TOG: rows[i][j] <= ~rows[i][j];
                  default: rows[i][j] <= rows[i][j];
                endcase
              end
            end
          end
        end
      end
    end
  end

  always_comb begin
    rd_sel = '0;
    occ    = '0;
    for (int i = 0; i < N; i++) begin
      if (bus.rd_row == RW'(i)) rd_sel = rows[i];
      occ = occ | rows[i];
    end
  end

  diag_checker #(.N(N)) u_diag (
    .board   (rows),
    .chk_row (bus.chk_row),
    .chk_col (bus.chk_col),
    .safe    (safe_comb)
  );

  // Outputs sample the pre-edge board, so a write shows up one cycle after it lands.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.rd_data  <= '0;
      bus.col_occ  <= '0;
      bus.chk_safe <= 1'b0;
    end else begin
      bus.rd_data  <= rd_sel;
      bus.col_occ  <= occ;
      bus.chk_safe <= safe_comb;
    end
  end

endmodule

// File: tb/tb_board_register_file.sv
// Bench for board_register_file: N=8 and N=6 instances against a behavioural board model.
module tb_board_register_file;
  import queen_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  board_register_file_if #(.N(8)) b8();
  board_register_file_if #(.N(6)) b6();

  board_register_file #(.N(8)) dut8 (.clk(clk), .rst(rst), .bus(b8));
  board_register_file #(.N(6)) dut6 (.clk(clk), .rst(rst), .bus(b6));

  logic [15:0] mb [2][16];
  int          sw [2];
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic ref_safe(input int k, input int n, input int cr, input int cc);
    if (cr >= n || cc >= n) return 1'b0;
    for (int r = 0; r < cr; r++) begin
      int d;
      d = cr - r;
      if (mb[k][r][cc]) return 1'b0;
      if (cc - d >= 0 && mb[k][r][cc - d]) return 1'b0;
      if (cc + d < n && mb[k][r][cc + d]) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic model_step(input int k, input int n, input logic r, input logic clr,
                            input logic we, input int mode, input int row, input int col,
                            input logic [15:0] data, input int rdr, input int chr, input int chc,
                            output logic [15:0] rd_e, output logic [15:0] col_e,
                            output logic chk_e, output logic busy_e);
    logic [15:0] mask;
    mask  = 16'((32'd1 << n) - 1);
    rd_e  = (rdr < n) ? mb[k][rdr] : 16'h0;
    col_e = 16'h0;
    for (int i = 0; i < n; i++) col_e = col_e | mb[k][i];
    chk_e = ref_safe(k, n, chr, chc);
    if (r) begin
      for (int i = 0; i < 16; i++) mb[k][i] = 16'h0;
      sw[k] = -1;
      rd_e  = 16'h0;
      col_e = 16'h0;
      chk_e = 1'b0;
    end else if (sw[k] >= 0) begin
      mb[k][sw[k]] = 16'h0;
      sw[k]++;
      if (sw[k] == n) sw[k] = -1;
    end else begin
      if (we && row < n) begin
        if (mode == 0) mb[k][row] = data & mask;
        else if (col < n) begin
          if (mode == 1) mb[k][row][col] = 1'b1;
          else if (mode == 2) mb[k][row][col] = 1'b0;
          else mb[k][row][col] = ~mb[k][row][col];
        end
      end
      if (clr) sw[k] = 0;
    end
    busy_e = (sw[k] >= 0);
  endtask

  task automatic cyc();
    logic [15:0] rd_e [2];
    logic [15:0] col_e [2];
    logic        chk_e [2];
    logic        busy_e [2];
    model_step(0, 8, rst, b8.clr_start, b8.wr_en, int'(b8.wr_mode), int'(b8.wr_row),
               int'(b8.wr_col), 16'(b8.wr_data), int'(b8.rd_row), int'(b8.chk_row),
               int'(b8.chk_col), rd_e[0], col_e[0], chk_e[0], busy_e[0]);
    model_step(1, 6, rst, b6.clr_start, b6.wr_en, int'(b6.wr_mode), int'(b6.wr_row),
               int'(b6.wr_col), 16'(b6.wr_data), int'(b6.rd_row), int'(b6.chk_row),
               int'(b6.chk_col), rd_e[1], col_e[1], chk_e[1], busy_e[1]);
    @(posedge clk);
    #1;
    chk("rd8",   16'(b8.rd_data),  rd_e[0]);
    chk("col8",  16'(b8.col_occ),  col_e[0]);
    chk("chk8",  16'(b8.chk_safe), 16'(chk_e[0]));
    chk("busy8", 16'(b8.busy),     16'(busy_e[0]));
    chk("rd6",   16'(b6.rd_data),  rd_e[1]);
    chk("col6",  16'(b6.col_occ),  col_e[1]);
    chk("chk6",  16'(b6.chk_safe), 16'(chk_e[1]));
    chk("busy6", 16'(b6.busy),     16'(busy_e[1]));
  endtask

  task automatic idle();
    b8.wr_en = 1'b0; b8.clr_start = 1'b0;
    b6.wr_en = 1'b0; b6.clr_start = 1'b0;
  endtask

  task automatic wr8(input wr_mode_t m, input int row, input int col, input logic [7:0] d);
    b8.wr_en   = 1'b1;
    b8.wr_mode = m;
    b8.wr_row  = 3'(row);
    b8.wr_col  = 3'(col);
    b8.wr_data = d;
    cyc();
    b8.wr_en = 1'b0;
  endtask

  task automatic probe8(input int r, input int c, input logic exp, input string tag);
    b8.chk_row = 3'(r);
    b8.chk_col = 3'(c);
    cyc();
    chk(tag, 16'(b8.chk_safe), 16'(exp));
  endtask

  initial begin
    int busy_cnt;
    for (int k = 0; k < 2; k++) begin
      sw[k] = -1;
      for (int i = 0; i < 16; i++) mb[k][i] = 16'h0;
    end
    rst = 1'b1;
    idle();
    b8.wr_mode = ROW_LOAD; b8.wr_row = '0; b8.wr_col = '0; b8.wr_data = '0;
    b8.rd_row = '0; b8.chk_row = '0; b8.chk_col = '0;
    b6.wr_mode = ROW_LOAD; b6.wr_row = '0; b6.wr_col = '0; b6.wr_data = '0;
    b6.rd_row = '0; b6.chk_row = '0; b6.chk_col = '0;
    cyc();
    chk("reset_rd", 16'(b8.rd_data), 16'h0);
    chk("reset_busy", 16'(b8.busy), 16'h0);
    rst = 1'b0;

    // Reset mid-sweep
    wr8(ROW_LOAD, 3, 0, 8'hA5);
    b8.clr_start = 1'b1;
    cyc();
    b8.clr_start = 1'b0;
    cyc();
    chk("t1_busy_mid", 16'(b8.busy), 16'h1);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("t1_busy_after_rst", 16'(b8.busy), 16'h0);
    b8.rd_row = 3'd3;
    cyc();
    chk("t1_rd_row3", 16'(b8.rd_data), 16'h0);
    chk("t1_col_occ", 16'(b8.col_occ), 16'h0);

    // Row load, toggle, bit set
    wr8(ROW_LOAD, 2, 0, 8'h81);
    wr8(BIT_TOG, 2, 0, 8'h00);
    b8.rd_row = 3'd2;
    cyc();
    chk("t2_tog", 16'(b8.rd_data), 16'h80);
    wr8(BIT_SET, 5, 6, 8'h00);
    cyc();
    chk("t2_col_occ", 16'(b8.col_occ), 16'hC0);

    // Same-cycle read/write returns the old row
    b8.rd_row = 3'd4;
    wr8(ROW_LOAD, 4, 0, 8'h0F);
    chk("t3_old", 16'(b8.rd_data), 16'h00);
    cyc();
    chk("t3_new", 16'(b8.rd_data), 16'h0F);

    // Probe around a queen at (0,3)
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    wr8(BIT_SET, 0, 3, 8'h00);
    probe8(1, 3, 1'b0, "t4_1_3");
    probe8(1, 4, 1'b0, "t4_1_4");
    probe8(2, 1, 1'b0, "t4_2_1");
    probe8(2, 2, 1'b1, "t4_2_2");
    probe8(0, 5, 1'b1, "t4_0_x");

    // Full board, double clr_start, write during sweep
    for (int i = 0; i < 8; i++) wr8(ROW_LOAD, i, 0, 8'hFF);
    b8.clr_start = 1'b1;
    cyc();
    busy_cnt = b8.busy ? 1 : 0;
    for (int i = 0; i < 20 && b8.busy; i++) begin
      idle();
      if (i == 0) b8.clr_start = 1'b1;
      if (i == 3) begin
        b8.wr_en = 1'b1; b8.wr_mode = ROW_LOAD; b8.wr_row = 3'd0; b8.wr_data = 8'hFF;
      end
      cyc();
      if (b8.busy) busy_cnt++;
    end
    idle();
    chk("t5_busy_cycles", 16'(busy_cnt), 16'd8);
    for (int i = 0; i < 8; i++) begin
      b8.rd_row = 3'(i);
      cyc();
      chk("t5_row_zero", 16'(b8.rd_data), 16'h0);
    end

    // N=6 out-of-range handling
    b6.wr_en = 1'b1; b6.wr_mode = ROW_LOAD; b6.wr_row = 3'd7; b6.wr_data = 6'h3F;
    cyc();
    b6.wr_en = 1'b0;
    cyc();
    chk("t6_col_occ", 16'(b6.col_occ), 16'h0);
    b6.rd_row = 3'd6;
    cyc();
    chk("t6_rd_oob", 16'(b6.rd_data), 16'h0);
    b6.wr_en = 1'b1; b6.wr_mode = BIT_SET; b6.wr_row = 3'd0; b6.wr_col = 3'd1;
    cyc();
    b6.wr_en = 1'b0;
    b6.chk_row = 3'd2; b6.chk_col = 3'd5;
    cyc();
    chk("t6_diag_skip", 16'(b6.chk_safe), 16'h1);
    b6.chk_row = 3'd6; b6.chk_col = 3'd2;
    cyc();
    chk("t6_chk_oob", 16'(b6.chk_safe), 16'h0);

    // Randomized traffic on both boards
    for (int n = 0; n < 500; n++) begin
      rst          = ($urandom_range(0, 79) == 0);
      b8.wr_en     = ($urandom_range(0, 2) != 0);
      b8.clr_start = ($urandom_range(0, 24) == 0);
      b8.wr_mode   = wr_mode_t'($urandom_range(0, 3));
      b8.wr_row    = 3'($urandom_range(0, 7));
      b8.wr_col    = 3'($urandom_range(0, 7));
      b8.wr_data   = 8'($urandom);
      b8.rd_row    = 3'($urandom_range(0, 7));
      b8.chk_row   = 3'($urandom_range(0, 7));
      b8.chk_col   = 3'($urandom_range(0, 7));
      b6.wr_en     = ($urandom_range(0, 2) != 0);
      b6.clr_start = ($urandom_range(0, 24) == 0);
      b6.wr_mode   = wr_mode_t'($urandom_range(0, 3));
      b6.wr_row    = 3'($urandom_range(0, 7));
      b6.wr_col    = 3'($urandom_range(0, 7));
      b6.wr_data   = 6'($urandom);
      b6.rd_row    = 3'($urandom_range(0, 7));
      b6.chk_row   = 3'($urandom_range(0, 7));
      b6.chk_col   = 3'($urandom_range(0, 7));
      cyc();
    end
    rst = 1'b0;
    idle();
    cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
